// File: rtl/axi4lite_read_slave_q_if.sv
// Bundle of the AXI4-Lite read channels (AR/R) and the register-backend request/response
// handshake, seen from the slave (DUT) and from the master/backend side (bench or fabric).
interface axi4lite_read_slave_q_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned OFF_W  = 12
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              req_valid;
    logic              req_ready;
    logic [OFF_W-1:0]  req_addr;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport slave (
        input  arvalid, araddr, arprot, rready, req_ready, rsp_valid, rsp_data, rsp_err,
        output arready, rvalid, rdata, rresp, req_valid, req_addr
    );

    modport master (
        output arvalid, araddr, arprot, rready, req_ready, rsp_valid, rsp_data, rsp_err,
        input  arready, rvalid, rdata, rresp, req_valid, req_addr
    );
endinterface

// File: rtl/axi4lite_read_slave_q.sv
// AXI4-Lite read slave: AR commands are classified on arrival, queued, and served in order,
// one backend transaction at a time; errored commands bypass the backend entirely.
module axi4lite_read_slave_q #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DEPTH     = 4,
    parameter logic [ADDR_W-1:0] BASE      = '0,
    parameter int unsigned       SIZE      = 4096,
    parameter bit                PRIV_ONLY = 1'b0
) (
    input logic                     aclk,
    input logic                     areset,
    axi4lite_read_slave_q_if.slave  bus
);
    localparam int unsigned       OFF_W    = $clog2(SIZE);
    localparam int unsigned       LSB_W    = $clog2(DATA_W / 8);
    localparam int unsigned       PTR_W    = $clog2(DEPTH);
    localparam int unsigned       CNT_W    = PTR_W + 1;
    localparam logic [ADDR_W-1:0] WIN_MASK = ADDR_W'(SIZE - 1);

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

    typedef struct packed {
        logic [OFF_W-1:0] offset;
        resp_e            code;
    } entry_t;

    entry_t            queue_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              arready_q, arready_d;
    state_e            state_q, state_d;
    logic [OFF_W-1:0]  req_addr_q, req_addr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    resp_e             rresp_q, rresp_d;
    entry_t            push_entry, head;
    logic              push, pop, retire;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        push_entry.offset = bus.araddr[OFF_W-1:0];
        push_entry.code   = RESP_OKAY;
        if ((bus.araddr & ~WIN_MASK) != BASE) begin
            push_entry.code = RESP_DECERR;
        end else if (bus.araddr[LSB_W-1:0] != '0) begin
            push_entry.code = RESP_SLVERR;
        end else if (PRIV_ONLY && !bus.arprot[0]) begin
            push_entry.code = RESP_SLVERR;
        end
    end

    // count covers queued entries plus the one being served, so a slot frees only at the R handshake.
    assign head      = queue_q[rd_ptr_q];
    assign push      = bus.arvalid && arready_q;
    assign pop       = (state_q == S_IDLE) && (count_q != '0);
    assign retire    = (state_q == S_RESP) && bus.rready;
    assign wr_ptr_d  = wr_ptr_q + PTR_W'(push);
    assign rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    assign count_d   = count_q + CNT_W'(push) - CNT_W'(retire);
    assign arready_d = (count_d != CNT_W'(DEPTH));

    // NOTE: queue storage has no reset; an entry is only read after count marks it written.
    always_ff @(posedge aclk) begin
        if (push) begin
            queue_q[wr_ptr_q] <= push_entry;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    if (head.code == RESP_OKAY) begin
                        state_d    = S_REQ;
                        req_addr_d = head.offset;
                    end else begin
                        state_d = S_RESP;
                        rdata_d = '0;
                        rresp_d = head.code;
                    end
                end
            end
            S_REQ: begin
                if (bus.req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.rsp_valid) begin
                    state_d = S_RESP;
                    rdata_d = bus.rsp_data;
                    rresp_d = bus.rsp_err ? RESP_SLVERR : RESP_OKAY;
                end
            end
            S_RESP: begin
                if (bus.rready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            arready_q  <= 1'b0;
            state_q    <= S_IDLE;
            req_addr_q <= '0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            arready_q  <= arready_d;
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign bus.arready   = arready_q;
    assign bus.rvalid    = (state_q == S_RESP);
    assign bus.rdata     = rdata_q;
    assign bus.rresp     = rresp_q;
    assign bus.req_valid = (state_q == S_REQ);
    assign bus.req_addr  = req_addr_q;
endmodule
